// File: rtl/dmem_if_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : dmem_if_pkg
//  Description : Shared types and widths for the core's req/gnt/rvalid
//                data-memory interface. Used by the core-side initiator and
//                by the memory-side responder.
//  Contents    : BE_W / DATA_W / ADDR_W widths, response struct dmem_rsp_t.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_if_pkg;

  localparam int unsigned BE_W   = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;

  // One response beat. A cleared struct is the idle state: valid=0 with
  // rdata and err also 0, so the output can be driven straight from it.
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] rdata;
    logic              err;
  } dmem_rsp_t;

endpackage : dmem_if_pkg
`default_nettype wire

// File: rtl/dmem_resp_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_resp_pipe
//  Description : LATENCY-stage shift register of response structs. Stage 0
//                takes the response on an accept and is cleared otherwise, so
//                empty slots stay all-zero and the last stage can drive the
//                interface outputs directly.
//  Ports       : clk     - clock
//                reset   - synchronous active-high clear of every stage
//                load    - accept strobe; loads rsp_in into stage 0
//                rsp_in  - response to enqueue
//                rsp_out - response leaving the last stage
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_resp_pipe
  import dmem_if_pkg::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      load,
  input  dmem_rsp_t rsp_in,
  output dmem_rsp_t rsp_out
);

  dmem_rsp_t stage [LATENCY];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(LATENCY); i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= load ? rsp_in : '0;
      for (int i = 1; i < int'(LATENCY); i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign rsp_out = stage[LATENCY-1];

endmodule : dmem_resp_pipe
`default_nettype wire

// File: rtl/dmem_obi_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_obi_responder
//  Description : Memory-side responder for the core's req/gnt/rvalid data
//                interface. Grants requests (bounded by MAX_OUTSTANDING and a
//                grant-hold input), performs byte-enabled stores into a local
//                word RAM and returns one response per accept, in order,
//                LATENCY cycles after the accept edge.
//  Ports       : clk, reset (sync, active-high)
//                data_req_i/addr_i/we_i/be_i/wdata_i - request from initiator
//                gnt_hold_i    - forces data_gnt_o low
//                data_gnt_o    - combinational grant
//                data_rvalid_o - one-cycle response pulse
//                data_rdata_o  - load data (0 for stores / out of window)
//                data_err_o    - address was outside the RAM window
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_obi_responder
  import dmem_if_pkg::*;
#(
  parameter int unsigned       DEPTH_WORDS     = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned       LATENCY         = 1,
  parameter int unsigned       MAX_OUTSTANDING = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_req_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic              data_we_i,
  input  logic [BE_W-1:0]   data_be_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  input  logic              gnt_hold_i,
  output logic              data_gnt_o,
  output logic              data_rvalid_o,
  output logic [DATA_W-1:0] data_rdata_o,
  output logic              data_err_o
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  // Window bounds in 33 bits so BASE_ADDR + size never wraps around.
  localparam logic [ADDR_W:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] WIN_HI = {1'b0, BASE_ADDR} + (ADDR_W+1)'(4 * DEPTH_WORDS);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  logic [CNT_W-1:0]  outstanding;
  logic [ADDR_W-1:0] offset;
  logic [IDX_W-1:0]  word_idx;
  logic              in_range;
  logic              accept;
  dmem_rsp_t         rsp_in;
  dmem_rsp_t         rsp_out;
  logic              unused_offset_bits;

  // --------------------------------------------------------------------------
  // Window decode. addr[1:0] is dropped: the initiator aligns lanes via be.
  // --------------------------------------------------------------------------
  always_comb begin
    in_range = ({1'b0, data_addr_i} >= WIN_LO) && ({1'b0, data_addr_i} < WIN_HI);
    offset   = data_addr_i - BASE_ADDR;
    word_idx = offset[IDX_W+1:2];
  end

  assign unused_offset_bits = ^{offset[ADDR_W-1:IDX_W+2], offset[1:0]};

  // --------------------------------------------------------------------------
  // Grant. A response leaving this cycle frees a slot, so a full counter can
  // still grant when rvalid is high.
  // --------------------------------------------------------------------------
  always_comb begin
    data_gnt_o = data_req_i && !gnt_hold_i && !reset &&
                 ((outstanding < CNT_W'(MAX_OUTSTANDING)) || data_rvalid_o);
    accept     = data_req_i && data_gnt_o;
  end

  // --------------------------------------------------------------------------
  // RAM: byte-lane writes on an in-window store accept. No reset, so contents
  // survive reset. The load path reads the pre-edge value, which gives
  // read-before-write against a store on the same edge.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (accept && data_we_i && in_range) begin
      for (int i = 0; i < int'(BE_W); i++) begin
        if (data_be_i[i]) begin
          mem[word_idx][8*i +: 8] <= data_wdata_i[8*i +: 8];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Response formation for the beat entering the pipe.
  // --------------------------------------------------------------------------
  always_comb begin
    rsp_in = '0;
    if (accept) begin
      rsp_in.valid = 1'b1;
      if (!in_range) begin
        rsp_in.err = 1'b1;
      end else if (!data_we_i) begin
        rsp_in.rdata = mem[word_idx];
      end
    end
  end

  dmem_resp_pipe #(
    .LATENCY (LATENCY)
  ) u_resp_pipe (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .rsp_in  (rsp_in),
    .rsp_out (rsp_out)
  );

  assign data_rvalid_o = rsp_out.valid;
  assign data_rdata_o  = rsp_out.rdata;
  assign data_err_o    = rsp_out.err;

  // --------------------------------------------------------------------------
  // Outstanding counter: +1 on accept, -1 on rvalid, hold when both.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      case ({accept, data_rvalid_o})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule : dmem_obi_responder
`default_nettype wire
